// File: rtl/paint_pkg.sv
// Shared colours, palette lookup and draw FSM state type for the paint canvas.
package paint_pkg;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] PURPLE = 16'h801F;
  localparam logic [15:0] BROWN  = 16'hA145;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GREY   = 16'h8410;

  localparam logic [2:0] IDX_BLACK = 3'd6;
  localparam logic [2:0] IDX_WHITE = 3'd7;

  typedef enum logic [1:0] {StIdle, StStamp, StClear} state_e;

  function automatic logic [15:0] palette(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0:    c = RED;
      3'd1:    c = ORANGE;
      3'd2:    c = GREEN;
      3'd3:    c = BLUE;
      3'd4:    c = PURPLE;
      3'd5:    c = BROWN;
      3'd6:    c = BLACK;
      default: c = WHITE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/canvas_ram.sv
// Per-cell palette index store: one synchronous write port, one registered read port.
module canvas_ram #(
  parameter int unsigned DEPTH = 544,
  parameter int unsigned WIDTH = 3,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_100M,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_100M) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/paint_canvas.sv
// Paint canvas: palette toolbar, brush stamping into cell RAM, clear sweep and pixel fetch.
module paint_canvas
  import paint_pkg::*;
#(
  parameter int unsigned SCREEN_W  = 96,
  parameter int unsigned SCREEN_H  = 64,
  parameter int unsigned TOOLBAR_H = 13,
  parameter int unsigned CELL      = 3,
  parameter int unsigned PALETTE_N = 8
) (
  input  logic        clk_100M,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        mouse_l,
  input  logic        mouse_r,
  input  logic [11:0] mouse_x,
  input  logic [11:0] mouse_y,
  input  logic [1:0]  brush_size,
  input  logic [12:0] pixel_index,
  output logic [15:0] colour_out,
  output logic [2:0]  sel_colour,
  output logic        busy
);

  localparam int unsigned COLS  = SCREEN_W / CELL;
  localparam int unsigned ROWS  = (SCREEN_H - TOOLBAR_H) / CELL;
  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned SW    = SCREEN_W / PALETTE_N;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned RW    = $clog2(ROWS);

  localparam logic signed [12:0] TB_S = 13'(TOOLBAR_H);
  localparam logic signed [12:0] CH_S = 13'(ROWS * CELL);
  localparam logic signed [12:0] CW_S = 13'(COLS * CELL);
  localparam logic signed [12:0] PW_S = 13'(PALETTE_N * SW);

  // Button synchronisers and left-button edge detect
  logic l_meta, l_sync, l_prev, r_meta, r_sync, l_rise;

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      l_meta <= 1'b0;
      l_sync <= 1'b0;
      l_prev <= 1'b0;
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      l_meta <= mouse_l;
      l_sync <= l_meta;
      l_prev <= l_sync;
      r_meta <= mouse_r;
      r_sync <= r_meta;
    end
  end

  assign l_rise = l_sync & ~l_prev;

  // Mouse position decode, signed so coordinates above the canvas never alias in
  logic signed [12:0] mx_s, my_s, my_off;
  logic        [12:0] my_off_u;
  logic               m_valid;

  assign mx_s     = $signed({1'b0, mouse_x});
  assign my_s     = $signed({1'b0, mouse_y});
  assign my_off   = my_s - TB_S;
  assign my_off_u = my_off;
  assign m_valid  = (my_off >= 13'sd0) && (my_off < CH_S) && (mx_s < CW_S);

  logic [2:0] sel_q;

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      sel_q <= IDX_BLACK;
    end else if (enable && l_rise && (my_s < TB_S) && (mx_s < PW_S)) begin
      sel_q <= 3'(mouse_x / 12'(SW));
    end
  end

  assign sel_colour = sel_q;

  // Draw FSM
  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic            busy_q;
  logic [CW-1:0]   cx_q;
  logic [RW-1:0]   cy_q;
  logic [1:0]      dx_q, dy_q, last_q;
  logic [2:0]      ink_q;

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      addr_q  <= '0;
      busy_q  <= 1'b1;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      last_q  <= '0;
      ink_q   <= '0;
    end else if (clear) begin
      state_q <= StClear;
      addr_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && (l_sync || r_sync) && m_valid) begin
            cx_q    <= CW'(mouse_x / 12'(CELL));
            cy_q    <= RW'(my_off_u / 13'(CELL));
            last_q  <= (brush_size == 2'd3) ? 2'd2 : brush_size;
            ink_q   <= r_sync ? IDX_WHITE : sel_q;
            dx_q    <= '0;
            dy_q    <= '0;
            state_q <= StStamp;
          end
        end
        StStamp: begin
          if (dx_q == last_q) begin
            dx_q <= '0;
            if (dy_q == last_q) state_q <= StIdle;
            else                dy_q    <= dy_q + 2'd1;
          end else begin
            dx_q <= dx_q + 2'd1;
          end
        end
        StClear: begin
          if (addr_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;

  // Stamp target; off-canvas cells still take their cycle but are not written
  logic [CW:0]   tx;
  logic [RW:0]   ty;
  logic          t_in;
  logic [AW-1:0] stamp_addr;

  assign tx         = {1'b0, cx_q} + (CW+1)'(dx_q);
  assign ty         = {1'b0, cy_q} + (RW+1)'(dy_q);
  assign t_in       = (tx < (CW+1)'(COLS)) && (ty < (RW+1)'(ROWS));
  assign stamp_addr = AW'(ty) * AW'(COLS) + AW'(tx);

  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [2:0]    wdata, rdata;

  always_comb begin
    we    = 1'b0;
    waddr = addr_q;
    wdata = IDX_WHITE;
    if (state_q == StClear) begin
      we = 1'b1;
    end else if ((state_q == StStamp) && t_in) begin
      we    = 1'b1;
      waddr = stamp_addr;
      wdata = ink_q;
    end
  end

  canvas_ram #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_ram (
    .clk_100M (clk_100M),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata)
  );

  // Read path stage 1: pixel decode, RAM read, region flags
  logic        [12:0] p_row, p_col, row_off_u;
  logic signed [12:0] row_off;
  logic               p_swatch, p_toolbar, p_canvas;

  assign p_row     = pixel_index / 13'(SCREEN_W);
  assign p_col     = pixel_index % 13'(SCREEN_W);
  assign row_off   = $signed(p_row) - TB_S;
  assign row_off_u = row_off;
  assign p_toolbar = p_row < 13'(TOOLBAR_H);
  assign p_swatch  = (p_col / 13'(SW) < 13'(PALETTE_N)) && ((p_col % 13'(SW)) != '0) &&
                     (p_row > 13'd0) && (p_row < 13'(TOOLBAR_H - 1));
  assign p_canvas  = (row_off >= 13'sd0) && (row_off < CH_S) && ($signed(p_col) < CW_S);
  assign raddr     = p_canvas ?
                     AW'((row_off_u / 13'(CELL)) * 13'(COLS) + p_col / 13'(CELL)) : '0;

  logic [12:0] row_q, col_q;
  logic        swatch_q, toolbar_q, canvas_q;

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      col_q     <= '0;
      swatch_q  <= 1'b0;
      toolbar_q <= 1'b0;
      canvas_q  <= 1'b0;
    end else begin
      row_q     <= p_row;
      col_q     <= p_col;
      swatch_q  <= p_swatch;
      toolbar_q <= p_toolbar;
      canvas_q  <= p_canvas;
    end
  end

  // Stage 2: overlay priority and output register
  logic signed [12:0] dcx, dcy;
  logic               cursor;
  logic [15:0]        colour_d, colour_q;

  assign dcx    = $signed(col_q) - mx_s;
  assign dcy    = $signed(row_q) - my_s;
  assign cursor = (dcx >= -13'sd1) && (dcx <= 13'sd1) && (dcy >= -13'sd1) && (dcy <= 13'sd1);

  always_comb begin
    colour_d = WHITE;
    if (cursor)         colour_d = (sel_q == IDX_WHITE) ? GREY : palette(sel_q);
    else if (swatch_q)  colour_d = palette(3'(col_q / 13'(SW)));
    else if (toolbar_q) colour_d = GREY;
    else if (canvas_q)  colour_d = palette(rdata);
  end

  always_ff @(posedge clk_100M or posedge reset) begin
    if (reset)       colour_q <= 16'h0000;
    else if (enable) colour_q <= colour_d;
  end

  assign colour_out = colour_q;

endmodule

// File: tb/tb_paint_canvas.sv
// Scoreboarded bench for paint_canvas: reset sweep, palette pick, stamps, clear abort, reset.
module tb_paint_canvas;
  import paint_pkg::*;

  localparam logic [15:0] C_RED   = 16'hF800;
  localparam logic [15:0] C_BLUE  = 16'h001F;
  localparam logic [15:0] C_WHITE = 16'hFFFF;
  localparam logic [15:0] C_GREY  = 16'h8410;

  logic        clk_100M = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, enable = 1'b0, mouse_l = 1'b0, mouse_r = 1'b0;
  logic [11:0] mouse_x = 12'd4000, mouse_y = 12'd4000;
  logic [1:0]  brush_size = 2'd0;
  logic [12:0] pixel_index = 13'd0;
  logic [15:0] colour_out;
  logic [2:0]  sel_colour;
  logic        busy;

  paint_canvas dut (
    .clk_100M    (clk_100M),
    .reset       (reset),
    .clear       (clear),
    .enable      (enable),
    .mouse_l     (mouse_l),
    .mouse_r     (mouse_r),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .brush_size  (brush_size),
    .pixel_index (pixel_index),
    .colour_out  (colour_out),
    .sel_colour  (sel_colour),
    .busy        (busy)
  );

  always #5 clk_100M = ~clk_100M;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  typedef struct {
    int unsigned due;
    logic [15:0] want;
    int unsigned id;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic [15:0] model [544];

  // Pops every expectation whose pixel has reached colour_out
  always @(posedge clk_100M) begin
    exp_t e;
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_eq($sformatf("px_%0d", e.id), 32'(colour_out), 32'(e.want));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  task automatic read_px(input int x, input int y, input logic [15:0] want);
    @(negedge clk_100M);
    pixel_index = 13'(y * 96 + x);
    sb.push_back('{due: cyc + 2, want: want, id: 32'(y * 96 + x)});
  endtask

  task automatic drain();
    tick(4);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [15:0] px_model(input int x, input int y);
    return model[((y - 13) / 3) * 32 + x / 3];
  endfunction

  task automatic check_canvas();
    for (int r = 0; r < 17; r++)
      for (int c = 0; c < 32; c++) read_px(c * 3 + 1, 13 + r * 3 + 1, model[r * 32 + c]);
    drain();
  endtask

  task automatic park();
    mouse_x = 12'd4000;
    mouse_y = 12'd4000;
  endtask

  task automatic do_stamp(input string tag, input int x, input int y, input logic [1:0] bs,
                          input logic l, input logic r, input int want_len);
    int n, len;
    @(negedge clk_100M);
    brush_size = bs;
    mouse_x = 12'(x);
    mouse_y = 12'(y);
    mouse_l = l;
    mouse_r = r;
    n = 0;
    while (dut.state_q != StStamp && n < 20) begin tick(1); n++; end
    check_eq({tag, "_start"}, 32'(dut.state_q == StStamp), 32'd1);
    len = 0;
    while (dut.state_q == StStamp && len < 50) begin tick(1); len++; end
    check_eq({tag, "_len"}, len, want_len);
    mouse_l = 1'b0;
    mouse_r = 1'b0;
    tick(25);
    park();
  endtask

  task automatic pick(input int x, input logic [2:0] want);
    mouse_x = 12'(x);
    mouse_y = 12'd5;
    mouse_l = 1'b1;
    tick(5);
    check_eq("pick", 32'(sel_colour), 32'(want));
    mouse_l = 1'b0;
    tick(5);
    park();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 544; i++) model[i] = C_WHITE;
    enable = 1'b1;
    tick(3);
    check_eq("rst_colour", 32'(colour_out), 32'h0000);
    check_eq("rst_sel", 32'(sel_colour), 32'd6);
    check_eq("rst_busy", 32'(busy), 32'd1);

    reset = 1'b0;
    n = 0;
    while (busy && n < 2000) begin tick(1); n++; end
    check_eq("busy_len", n, 544);
    check_canvas();

    // Output hold and no stamp while disabled
    enable = 1'b0;
    pixel_index = 13'd0;
    tick(4);
    check_eq("hold_colour", 32'(colour_out), 32'(C_WHITE));
    mouse_x = 12'd31;
    mouse_y = 12'd29;
    mouse_l = 1'b1;
    tick(6);
    check_eq("dis_no_stamp", 32'(dut.state_q == StIdle), 32'd1);
    mouse_l = 1'b0;
    tick(5);
    park();
    enable = 1'b1;

    // Toolbar and out-of-screen pixels
    read_px(0, 0, C_GREY);
    read_px(5, 5, C_RED);
    read_px(12, 5, C_GREY);
    read_px(40, 6, C_BLUE);
    read_px(5, 12, C_GREY);
    read_px(8, 64, C_WHITE);
    drain();

    // Palette pick through the synchronisers
    @(negedge clk_100M);
    mouse_x = 12'd40;
    mouse_y = 12'd5;
    mouse_l = 1'b1;
    tick(1);
    check_eq("sel_sync_delay", 32'(sel_colour), 32'd6);
    n = 1;
    while (sel_colour !== 3'd3 && n < 8) begin tick(1); n++; end
    check_eq("sel_blue", 32'(sel_colour), 32'd3);
    check_eq("sel_latency", n, 3);
    mouse_l = 1'b0;
    tick(5);

    // Cursor overlay
    mouse_x = 12'd40;
    mouse_y = 12'd30;
    read_px(40, 30, C_BLUE);
    read_px(41, 31, C_BLUE);
    read_px(39, 29, C_BLUE);
    read_px(42, 30, px_model(42, 30));
    read_px(40, 32, px_model(40, 32));
    drain();
    park();

    // Clipped brushes at the right and bottom edges
    pick(5, 3'd0);
    do_stamp("clip_br", 94, 62, 2'd1, 1'b1, 1'b0, 4);
    model[16 * 32 + 31] = C_RED;
    do_stamp("clip_r", 94, 29, 2'd1, 1'b1, 1'b0, 4);
    model[5 * 32 + 31] = C_RED;
    model[6 * 32 + 31] = C_RED;
    check_canvas();

    // Right button wins over left
    do_stamp("paint", 31, 29, 2'd0, 1'b1, 1'b0, 1);
    model[5 * 32 + 10] = C_RED;
    read_px(31, 29, C_RED);
    drain();
    do_stamp("both", 31, 29, 2'd3, 1'b1, 1'b1, 9);
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) model[(5 + dy) * 32 + 10 + dx] = C_WHITE;
    check_canvas();

    // Clear on cycle 3 of a 9-cycle stamp
    @(negedge clk_100M);
    brush_size = 2'd2;
    mouse_x = 12'd61;
    mouse_y = 12'd38;
    mouse_l = 1'b1;
    n = 0;
    while (dut.state_q != StStamp && n < 20) begin tick(1); n++; end
    check_eq("clr_stamp_start", 32'(dut.state_q == StStamp), 32'd1);
    tick(2);
    clear = 1'b1;
    mouse_l = 1'b0;
    tick(1);
    clear = 1'b0;
    check_eq("clr_busy_rise", 32'(busy), 32'd1);
    check_eq("clr_abort", 32'(dut.state_q == StClear), 32'd1);
    n = 0;
    while (busy && n < 2000) begin tick(1); n++; end
    check_eq("clr_busy_len", n, 544);
    park();
    for (int i = 0; i < 544; i++) model[i] = C_WHITE;
    check_canvas();

    // Asynchronous reset in the middle of a stamp
    @(negedge clk_100M);
    brush_size = 2'd2;
    mouse_x = 12'd61;
    mouse_y = 12'd38;
    mouse_l = 1'b1;
    n = 0;
    while (dut.state_q != StStamp && n < 20) begin tick(1); n++; end
    check_eq("rst2_stamp_start", 32'(dut.state_q == StStamp), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst2_colour", 32'(colour_out), 32'h0000);
    check_eq("rst2_sel", 32'(sel_colour), 32'd6);
    check_eq("rst2_busy", 32'(busy), 32'd1);
    check_eq("rst2_state", 32'(dut.state_q == StClear), 32'd1);
    mouse_l = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
